// File: rtl/munoc_rchannel_arbiter.sv
// Round-robin R-channel arbiter with burst lock: one requester owns the link from
// its first accepted beat until its RLAST beat is accepted, so bursts never interleave.
module munoc_rchannel_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BW_PAYLOAD  = 48,
  parameter int BW_BEAT_CNT = 8,
  localparam int BW_IDX     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rstnn,
  input  logic [NUM_REQ-1:0]            rq_valid,
  input  logic [NUM_REQ-1:0]            rq_last,
  input  logic [NUM_REQ*BW_PAYLOAD-1:0] rq_payload,
  output logic [NUM_REQ-1:0]            rq_ready,
  output logic                          rvalid,
  output logic                          rlast,
  output logic [BW_PAYLOAD-1:0]         rpayload,
  input  logic                          rready,
  output logic [BW_IDX-1:0]             grant_idx,
  output logic                          locked,
  output logic [BW_BEAT_CNT-1:0]        beat_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // NUM_REQ need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [BW_IDX-1:0] wrap_inc(input logic [BW_IDX-1:0] v);
    if (v == BW_IDX'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return v + BW_IDX'(1);
    end
  endfunction

  state_e                 state_q, state_d;
  logic [BW_IDX-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BW_IDX-1:0]      lock_idx_q, lock_idx_d;
  logic [BW_BEAT_CNT-1:0] beat_cnt_q, beat_cnt_d;
  logic                   rst_done_q, rst_done_d;

  logic [BW_IDX-1:0]      sel_s;
  logic [BW_IDX-1:0]      cand_s;
  logic                   found_s;
  logic                   accept_s;

  // Source selection: forced to 0 until out of reset, lock owner while locked,
  // otherwise the first valid requester at or after rr_ptr.
  always_comb begin
    sel_s   = rr_ptr_q;
    cand_s  = rr_ptr_q;
    found_s = 1'b0;
    if (!rst_done_q) begin
      sel_s = '0;
    end else if (state_q == ST_LOCKED) begin
      sel_s = lock_idx_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found_s && rq_valid[cand_s]) begin
          sel_s   = cand_s;
          found_s = 1'b1;
        end else begin
          cand_s = wrap_inc(cand_s);
        end
      end
    end
  end

  // Zero-latency link mux; rvalid deliberately ignores rready.
  always_comb begin
    rvalid   = rst_done_q & rq_valid[sel_s];
    rlast    = rq_last[sel_s];
    rpayload = rq_payload[int'(sel_s)*BW_PAYLOAD +: BW_PAYLOAD];
    rq_ready = '0;
    if (rst_done_q) begin
      rq_ready[sel_s] = rready;
    end else begin
      rq_ready = '0;
    end
  end

  assign accept_s  = rvalid & rready;
  assign grant_idx = sel_s;
  assign locked    = (state_q == ST_LOCKED);
  assign beat_cnt  = beat_cnt_q;

  // Burst lock state machine and round-robin pointer update.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    beat_cnt_d = beat_cnt_q;
    rst_done_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !rlast) begin
          state_d    = ST_LOCKED;
          lock_idx_d = sel_s;
          beat_cnt_d = BW_BEAT_CNT'(1);
        end else if (accept_s) begin
          rr_ptr_d   = wrap_inc(sel_s);
          beat_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (accept_s && !rlast) begin
          beat_cnt_d = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + BW_BEAT_CNT'(1);
        end else if (accept_s) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = wrap_inc(lock_idx_q);
          beat_cnt_d = '0;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State registers; reset abandons any partial burst.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      beat_cnt_q <= '0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      beat_cnt_q <= beat_cnt_d;
      rst_done_q <= rst_done_d;
    end
  end

endmodule

// File: tb/tb_munoc_rchannel_arbiter.sv
// Bench for munoc_rchannel_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a burst-level reference model.
module tb_munoc_rchannel_arbiter;
  localparam int N   = 4;
  localparam int BWP = 48;
  localparam int BWC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstnn;
  logic [N-1:0]     rq_valid, rq_last, rq_ready;
  logic [N*BWP-1:0] rq_payload;
  logic             rvalid, rlast, rready;
  logic [BWP-1:0]   rpayload;
  logic [1:0]       grant_idx;
  logic             locked;
  logic [BWC-1:0]   beat_cnt;

  munoc_rchannel_arbiter #(.NUM_REQ(N), .BW_PAYLOAD(BWP), .BW_BEAT_CNT(BWC)) dut (
    .clk(clk), .rstnn(rstnn), .rq_valid(rq_valid), .rq_last(rq_last),
    .rq_payload(rq_payload), .rq_ready(rq_ready), .rvalid(rvalid), .rlast(rlast),
    .rpayload(rpayload), .rready(rready), .grant_idx(grant_idx), .locked(locked),
    .beat_cnt(beat_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Requester-side generator: each requester streams bursts of gen_len beats.
  int gen_len[N];
  int gen_pos[N];
  int gen_bid[N];
  logic [N-1:0] vmask;
  logic         rready_v;
  bit           rand_len;

  // Reference model of the arbiter at burst level.
  bit m_locked, m_rst_done;
  int m_owner, m_ptr, m_cnt;

  // Values sampled by the last step, for the literal checks.
  int       s_grant, s_cnt;
  bit       s_locked, s_rvalid;
  logic [N-1:0] s_ready;
  int       t2_exp[4] = '{0, 0, 2, 2};

  function automatic logic [BWP-1:0] pay(int i);
    return {8'(i), 16'(gen_bid[i]), 8'(gen_pos[i]), 16'hBEEF};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare, then advance model at the rising edge.
  task automatic step();
    int sel;
    bit ev, acc, is_last;
    logic [N-1:0] exp_ready;
    rq_valid = vmask;
    rready   = rready_v;
    for (int i = 0; i < N; i++) begin
      rq_last[i] = (gen_pos[i] == gen_len[i] - 1);
      rq_payload[i*BWP +: BWP] = pay(i);
    end
    #2;
    if (!m_rst_done) begin
      sel = 0;
    end else if (m_locked) begin
      sel = m_owner;
    end else begin
      sel = m_ptr;
      for (int k = N - 1; k >= 0; k--) begin
        if (vmask[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
      end
    end
    ev        = m_rst_done && vmask[sel];
    is_last   = (gen_pos[sel] == gen_len[sel] - 1);
    exp_ready = (m_rst_done && rready_v) ? N'(1 << sel) : '0;
    chk("rvalid",    64'(rvalid),    64'(ev));
    chk("grant_idx", 64'(grant_idx), 64'(sel));
    chk("locked",    64'(locked),    64'(m_locked));
    chk("beat_cnt",  64'(beat_cnt),  64'(m_cnt));
    chk("rq_ready",  64'(rq_ready),  64'(exp_ready));
    chk("rlast",     64'(rlast),     64'(is_last));
    chk("rpayload",  64'(rpayload),  64'(pay(sel)));
    s_grant  = int'(grant_idx);
    s_cnt    = int'(beat_cnt);
    s_locked = locked;
    s_rvalid = rvalid;
    s_ready  = rq_ready;
    acc = ev && rready_v;
    @(posedge clk);
    if (acc) begin
      if (is_last) begin
        m_locked     = 1'b0;
        m_ptr        = (sel + 1) % N;
        m_cnt        = 0;
        gen_pos[sel] = 0;
        gen_bid[sel]++;
        if (rand_len) gen_len[sel] = $urandom_range(1, 5);
      end else begin
        m_locked = 1'b1;
        m_owner  = sel;
        if (m_cnt < 255) m_cnt++;
        gen_pos[sel]++;
      end
    end
    m_rst_done = 1'b1;
    @(negedge clk);
  endtask

  // Pulse reset from a falling edge; outputs must drop immediately.
  task automatic apply_reset();
    rstnn = 1'b0;
    #2;
    chk("rst_locked",   64'(locked),    64'd0);
    chk("rst_grant",    64'(grant_idx), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt),  64'd0);
    chk("rst_rvalid",   64'(rvalid),    64'd0);
    m_locked = 1'b0; m_rst_done = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < N; i++) begin
      gen_pos[i] = 0;
      gen_bid[i]++;
    end
    @(negedge clk);
    rstnn = 1'b1;
  endtask

  initial begin
    rstnn = 1'b0; rq_valid = '0; rq_last = '0; rq_payload = '0; rready = 1'b0;
    vmask = '0; rready_v = 1'b0; rand_len = 1'b0;
    for (int i = 0; i < N; i++) begin
      gen_len[i] = 1; gen_pos[i] = 0; gen_bid[i] = 0;
    end
    @(negedge clk);
    apply_reset();

    // Req0 alone, 4-beat burst.
    gen_len[0] = 4; vmask = 4'b0001; rready_v = 1'b1;
    step();
    chk("first_cycle_rvalid", 64'(s_rvalid), 64'd0);
    chk("first_cycle_ready",  64'(s_ready),  64'd0);
    for (int b = 0; b < 4; b++) begin
      step();
      chk("t1_cnt",    64'(s_cnt),    64'(b));
      chk("t1_grant",  64'(s_grant),  64'd0);
      chk("t1_locked", 64'(s_locked), 64'(b > 0));
      chk("t1_rvalid", 64'(s_rvalid), 64'd1);
    end
    vmask = '0;
    step();
    chk("t1_rr_ptr", 64'(s_grant), 64'd1);
    chk("t1_cnt_end", 64'(s_cnt), 64'd0);

    // Req0 and req2, 2-beat bursts, no interleave.
    apply_reset();
    gen_len[0] = 2; gen_len[2] = 2; vmask = '0;
    step();
    vmask = 4'b0101;
    for (int b = 0; b < 4; b++) begin
      step();
      chk("t2_grant", 64'(s_grant), 64'(t2_exp[b]));
    end
    vmask = '0;
    step();
    chk("t2_rr_ptr", 64'(s_grant), 64'd3);

    // Req1 locked, rready low for 5 cycles while req3 is valid.
    gen_len[1] = 3; vmask = 4'b0010; rready_v = 1'b1;
    step();
    vmask = 4'b1010; rready_v = 1'b0;
    for (int b = 0; b < 5; b++) begin
      step();
      chk("t3_hold_grant", 64'(s_grant), 64'd1);
      chk("t3_hold_ready", 64'(s_ready), 64'd0);
    end
    rready_v = 1'b1;
    for (int b = 0; b < 2; b++) begin
      step();
      chk("t3_resume_grant", 64'(s_grant), 64'd1);
    end
    step();
    chk("t3_next_grant", 64'(s_grant), 64'd3);

    // All valid with single-beat bursts.
    apply_reset();
    for (int i = 0; i < N; i++) gen_len[i] = 1;
    vmask = 4'b1111;
    step();
    for (int b = 0; b < 8; b++) begin
      step();
      chk("t4_grant",  64'(s_grant),  64'(b % 4));
      chk("t4_locked", 64'(s_locked), 64'd0);
    end

    // Locked requester drops valid mid-burst while req0 is valid.
    gen_len[1] = 3; vmask = 4'b0010;
    step();
    chk("t5_grant_start", 64'(s_grant), 64'd1);
    vmask = 4'b0001;
    for (int b = 0; b < 3; b++) begin
      step();
      chk("t5_drop_rvalid", 64'(s_rvalid), 64'd0);
      chk("t5_drop_grant",  64'(s_grant),  64'd1);
    end
    vmask = 4'b0011;
    for (int b = 0; b < 2; b++) begin
      step();
      chk("t5_finish_grant", 64'(s_grant), 64'd1);
    end

    // Reset mid 4-beat burst.
    gen_len[2] = 4; vmask = 4'b0100;
    step(); step();
    apply_reset();
    step();
    chk("t6_rvalid", 64'(s_rvalid), 64'd0);
    chk("t6_locked", 64'(s_locked), 64'd0);
    step();
    chk("t6_rearb", 64'(s_grant), 64'd2);

    // Beat counter saturation on a long burst.
    apply_reset();
    gen_len[3] = 300; vmask = 4'b1000;
    step();
    for (int b = 0; b < 300; b++) begin
      step();
      if (b == 270) chk("t7_saturate", 64'(s_cnt), 64'd255);
    end

    // Randomized traffic.
    apply_reset();
    rand_len = 1'b1;
    for (int i = 0; i < N; i++) gen_len[i] = $urandom_range(1, 5);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) vmask[i] = ($urandom_range(0, 9) < 7);
      rready_v = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
